// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs to an external multiplier and accumulates products.
// Optional feature macro MAC_DOT_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module mac_dot_seq #(
  parameter int DW      = 8,
  parameter int ACC_W   = 32,
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_asigned,
  input  logic               cmd_wsigned,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [DW-1:0]      op_a,
  input  logic [DW-1:0]      op_w,
  output logic [DW-1:0]      mul_a,
  output logic [DW-1:0]      mul_w,
  output logic               mul_asigned,
  output logic               mul_wsigned,
  input  logic [2*DW:0]      mul_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic               res_ovf,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  localparam int PW = 2*DW+1;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // every ready/valid driven here is a register, and res_valid/res_data hold until taken.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               cmd_ready_q, op_ready_q, res_valid_q, busy_q;
  logic [LEN_W-1:0]   len_q, issued_q;
  logic               asigned_q, wsigned_q;
  logic [DW-1:0]      mul_a_q, mul_w_q;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic               take_q;
  logic [ACC_W-1:0]   acc_q, ext, sum, acc_add;
  logic               ovf_q, add_ovf;
  logic               cmd_fire, op_fire, res_fire;

  always_comb begin
    cmd_fire = cmd_valid & cmd_ready_q;
    op_fire  = op_valid & op_ready_q;
    res_fire = res_valid_q & res_ready;

    state_d = state_q;
    case (state_q)
      // A zero-length command passes through DRAIN (pipeline already empty) so that
      // res_valid appears one cycle after the accept, like every other command.
      S_IDLE:  if (cmd_fire) state_d = S_DRAIN;
      S_RUN:   if (op_fire && (issued_q + LEN_W'(1) == len_q)) state_d = S_DRAIN;
      S_DRAIN: if (vld_q == '0) state_d = S_DONE;
      S_DONE:  if (res_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE && cmd_fire && cmd_len != '0) state_d = S_RUN;

    vld_d    = '0;
    vld_d[0] = op_fire;
    for (int i = 1; i < MUL_LAT; i++) vld_d[i] = vld_q[i-1];

    // Products are always sign-extended; unsigned*unsigned products carry a 0 MSB.
    ext          = {ACC_W{mul_q[PW-1]}};
    ext[PW-1:0]  = mul_q;
    sum          = acc_q + ext;
    add_ovf      = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MAC_DOT_SAT_EN
    if (add_ovf) acc_add = ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else         acc_add = sum;
`else
    acc_add = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      len_q       <= '0;
      issued_q    <= '0;
      asigned_q   <= 1'b0;
      wsigned_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_w_q     <= '0;
      vld_q       <= '0;
      take_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      // cmd_ready only after a full IDLE cycle: gives the bubble after a result handshake.
      cmd_ready_q <= (state_q == S_IDLE) && (state_d == S_IDLE);
      op_ready_q  <= (state_d == S_RUN);
      res_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      vld_q       <= vld_d;
      // mul_q matches an issue one cycle after its tag leaves the shift register.
      take_q      <= vld_q[MUL_LAT-1];
      if (cmd_fire) begin
        len_q     <= cmd_len;
        issued_q  <= '0;
        asigned_q <= cmd_asigned;
        wsigned_q <= cmd_wsigned;
        acc_q     <= '0;
        ovf_q     <= 1'b0;
      end else if (take_q) begin
        acc_q <= acc_add;
        if (add_ovf) ovf_q <= 1'b1;
      end
      if (op_fire) begin
        mul_a_q  <= op_a;
        mul_w_q  <= op_w;
        issued_q <= issued_q + LEN_W'(1);
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign mul_a       = mul_a_q;
  assign mul_w       = mul_w_q;
  assign mul_asigned = asigned_q;
  assign mul_wsigned = wsigned_q;
  assign res_data    = acc_q;
  assign res_ovf     = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: 32-bit and 17-bit accumulator instances share all inputs,
// each fed by a one-stage multiplier model.
module tb_mac_dot_seq;
  localparam int DW = 8, LEN_W = 8, MUL_LAT = 1, PW = 17;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_as, cmd_ws, op_valid, res_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [DW-1:0]    op_a, op_w;

  logic             cmd_ready, op_ready, mul_as, mul_ws, res_valid, res_ovf, busy;
  logic [DW-1:0]    mul_a, mul_w;
  logic [PW-1:0]    mul_q;
  logic [31:0]      res_data;
  logic [1:0]       dbg_state;

  logic             cmd_ready17, op_ready17, mul_as17, mul_ws17, res_valid17, res_ovf17, busy17;
  logic [DW-1:0]    mul_a17, mul_w17;
  logic [PW-1:0]    mul_q17;
  logic [16:0]      res_data17;
  logic [1:0]       dbg_state17;

  mac_dot_seq #(.DW(DW), .ACC_W(32), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_asigned(cmd_as), .cmd_wsigned(cmd_ws), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_w(op_w), .mul_a(mul_a), .mul_w(mul_w), .mul_asigned(mul_as),
    .mul_wsigned(mul_ws), .mul_q(mul_q), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy), .dbg_state_o(dbg_state));

  mac_dot_seq #(.DW(DW), .ACC_W(17), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) u_dut17 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready17), .cmd_len(cmd_len),
    .cmd_asigned(cmd_as), .cmd_wsigned(cmd_ws), .op_valid(op_valid), .op_ready(op_ready17),
    .op_a(op_a), .op_w(op_w), .mul_a(mul_a17), .mul_w(mul_w17), .mul_asigned(mul_as17),
    .mul_wsigned(mul_ws17), .mul_q(mul_q17), .res_valid(res_valid17), .res_ready(res_ready),
    .res_data(res_data17), .res_ovf(res_ovf17), .busy(busy17), .dbg_state_o(dbg_state17));

  function automatic logic [PW-1:0] mul_model(input logic [7:0] a, input logic [7:0] w,
                                              input logic as, input logic ws);
    logic signed [8:0]  ea, ew;
    logic signed [17:0] p;
    ea = {as & a[7], a};
    ew = {ws & w[7], w};
    p  = ea * ew;
    return p[PW-1:0];
  endfunction

  always @(posedge clk) begin
    mul_q   <= mul_model(mul_a, mul_w, mul_as, mul_ws);
    mul_q17 <= mul_model(mul_a17, mul_w17, mul_as17, mul_ws17);
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int              len;
    bit              as;
    bit              ws;
    logic [0:7][7:0] a;
    logic [0:7][7:0] w;
    logic [31:0]     e32;
    bit              o32;
    logic [16:0]     e17w;
    logic [16:0]     e17s;
    bit              o17;
    int              gap;
    int              hold;
  } vec_t;

  function automatic vec_t mk(input int len, input bit as, input bit ws, input logic [63:0] a,
                              input logic [63:0] w, input logic [31:0] e32, input bit o32,
                              input logic [16:0] e17w, input logic [16:0] e17s, input bit o17,
                              input int gap, input int hold);
    vec_t v;
    v.len = len; v.as = as; v.ws = ws; v.a = a; v.w = w;
    v.e32 = e32; v.o32 = o32; v.e17w = e17w; v.e17s = e17s; v.o17 = o17;
    v.gap = gap; v.hold = hold;
    return v;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_op_ready"},  op_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"},  res_data, 0);
    chk({tag, "_res_ovf"},   res_ovf, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_mul_a"},     mul_a, 0);
    chk({tag, "_mul_w"},     mul_w, 0);
    chk({tag, "_mul_as"},    mul_as, 0);
    chk({tag, "_mul_ws"},    mul_ws, 0);
    chk({tag, "_res17"},     res_data17, 0);
  endtask

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_cmd_ready_wait"}, cmd_ready, 1);
  endtask

  // driver: one command, its operand stream, and the result handshake
  task automatic run_vec(input vec_t v, input int id);
    int    cyc, idx, wait_cnt;
    bit    seen_opr, got, fire;
    string t;
    logic [16:0] e17;
    t = $sformatf("v%0d", id);
`ifdef MAC_DOT_SAT_EN
    e17 = v.e17s;
`else
    e17 = v.e17w;
`endif
    wait_cmd_ready(t);
    cmd_valid = 1; cmd_len = LEN_W'(v.len); cmd_as = v.as; cmd_ws = v.ws;
    res_ready = (v.hold == 0);
    @(posedge clk); #1;
    cmd_valid = 0;
    cyc = 0; idx = 0; wait_cnt = 0; seen_opr = 0; got = 0;
    while (cyc < 200) begin
      if (res_valid) begin
        got = 1;
        break;
      end
      if (op_ready) seen_opr = 1;
      if (v.len == 0) begin
        op_valid = 1; op_a = 8'hAA; op_w = 8'h55;
      end else if (wait_cnt > 0) begin
        op_valid = 0; wait_cnt--;
      end else if (idx < v.len) begin
        op_valid = 1; op_a = v.a[idx]; op_w = v.w[idx];
      end else begin
        op_valid = 0;
      end
      fire = op_valid && op_ready && (v.len != 0);
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        idx++;
        wait_cnt = v.gap;
      end
    end
    op_valid = 0;
    chk({t, "_res_seen"}, got, 1);
    if (got) begin
      chk({t, "_data"},      res_data, v.e32);
      chk({t, "_ovf"},       res_ovf, v.o32);
      chk({t, "_data17"},    res_data17, e17);
      chk({t, "_ovf17"},     res_ovf17, v.o17);
      chk({t, "_mul_as"},    mul_as, v.as);
      chk({t, "_mul_ws"},    mul_ws, v.ws);
      chk({t, "_cmd_ready"}, cmd_ready, 0);
      chk({t, "_busy"},      busy, 1);
      if (v.gap == 0)
        chk({t, "_latency"}, cyc, (v.len == 0) ? 1 : v.len + MUL_LAT + 1);
      if (v.len == 0) chk({t, "_op_ready_never"}, seen_opr, 0);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk({t, "_hold_valid"}, res_valid, 1);
      chk({t, "_hold_data"},  res_data, v.e32);
      chk({t, "_hold_cmdrdy"}, cmd_ready, 0);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk({t, "_post_valid"},  res_valid, 0);
    chk({t, "_post_busy"},   busy, 0);
    chk({t, "_post_bubble"}, cmd_ready, 0);
  endtask

  vec_t vecs[9];

  initial begin
    cmd_valid = 0; cmd_len = '0; cmd_as = 0; cmd_ws = 0;
    op_valid = 0; op_a = '0; op_w = '0; res_ready = 0;

    vecs[0] = mk(4, 0, 0, 64'h01030507_00000000, 64'h02040608_00000000,
                 32'd100, 0, 17'd100, 17'd100, 0, 0, 0);
    vecs[1] = mk(2, 1, 1, 64'h80010000_00000000, 64'h7F010000_00000000,
                 32'hFFFFC081, 0, 17'h1C081, 17'h1C081, 0, 0, 0);
    vecs[2] = mk(0, 0, 0, 64'h0, 64'h0, 32'd0, 0, 17'd0, 17'd0, 0, 0, 0);
    vecs[3] = mk(3, 1, 0, 64'hFF108000_00000000, 64'h0210FF00_00000000,
                 32'hFFFF817E, 0, 17'h1817E, 17'h1817E, 0, 0, 0);
    vecs[4] = mk(2, 0, 1, 64'hFF030000_00000000, 64'hFF800000_00000000,
                 32'hFFFFFD81, 0, 17'h1FD81, 17'h1FD81, 0, 0, 0);
    vecs[5] = mk(2, 0, 0, 64'hFFFF0000_00000000, 64'hFFFF0000_00000000,
                 32'h0001FC02, 0, 17'h1FC02, 17'h0FFFF, 1, 0, 0);
    vecs[6] = mk(4, 0, 0, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000,
                 32'h0003F804, 0, 17'h1F804, 17'h0FFFF, 1, 0, 0);
    vecs[7] = mk(5, 1, 1, 64'h80808080_80000000, 64'h7F7F7F7F_7F000000,
                 32'hFFFEC280, 0, 17'h0C280, 17'h10000, 1, 0, 0);
    vecs[8] = mk(3, 1, 0, 64'hFF108000_00000000, 64'h0210FF00_00000000,
                 32'hFFFF817E, 0, 17'h1817E, 17'h1817E, 0, 2, 5);

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // abort: reset after two of four pairs have been issued
    wait_cmd_ready("abort");
    cmd_valid = 1; cmd_len = 8'd4; cmd_as = 1; cmd_ws = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("abort_op_ready", op_ready, 1);
    op_valid = 1; op_a = 8'd9; op_w = 8'd9;
    @(posedge clk); #1;
    op_a = 8'd7; op_w = 8'd7;
    @(posedge clk); #1;
    op_valid = 0;
    chk("abort_mul_a_pre", mul_a, 8'd7);
    rst = 1;
    @(posedge clk); #1;
    check_zero("abort");
    rst = 0;
    run_vec(mk(1, 0, 0, 64'h03000000_00000000, 64'h03000000_00000000,
               32'd9, 0, 17'd9, 17'd9, 0, 0, 0), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
